// File: rtl/maze_pixel_renderer.sv
// Per-pixel maze renderer: 1-bit wall tile map, NUM_SPRITES sprite overlay, per-frame wall collisions.
// Latency: 3 cycles from x/y/pix_valid to r/g/b/rgb_valid, one pixel per cycle.
// Backpressure: none; the pipeline always advances and map clears do not stall pixel reads.
// Ports: clk/reset (async active-low); x, y, pix_valid from video_driver; wr_en/wr_col/wr_row/wr_data
// and clr_map/map_busy for map updates; spr_* packed sprite bounds/colours sampled with each pixel;
// r, g, b, rgb_valid out; collide/frame_done report the previous complete frame's collisions.
module maze_pixel_renderer #(
  parameter int          TILE_SHIFT  = 3,
  parameter int          TILE_COLS   = 80,
  parameter int          TILE_ROWS   = 60,
  parameter int          NUM_SPRITES = 2,
  parameter int          X_W         = 10,
  parameter int          Y_W         = 9,
  parameter logic [23:0] WALL_RGB    = 24'h0000FF,
  parameter logic [23:0] BG_RGB      = 24'h000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [X_W-1:0]               x,
  input  logic [Y_W-1:0]               y,
  input  logic                         pix_valid,
  input  logic                         wr_en,
  input  logic [$clog2(TILE_COLS)-1:0] wr_col,
  input  logic [$clog2(TILE_ROWS)-1:0] wr_row,
  input  logic                         wr_data,
  input  logic                         clr_map,
  output logic                         map_busy,
  input  logic [NUM_SPRITES-1:0]       spr_en,
  input  logic [NUM_SPRITES*X_W-1:0]   spr_left,
  input  logic [NUM_SPRITES*X_W-1:0]   spr_right,
  input  logic [NUM_SPRITES*Y_W-1:0]   spr_top,
  input  logic [NUM_SPRITES*Y_W-1:0]   spr_bot,
  input  logic [NUM_SPRITES*24-1:0]    spr_rgb,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b,
  output logic                         rgb_valid,
  output logic [NUM_SPRITES-1:0]       collide,
  output logic                         frame_done
);

  localparam int DEPTH  = TILE_COLS * TILE_ROWS;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;

  // ---------------- tile addressing for the incoming pixel ----------------
  logic [X_W-1:0]    pix_col;
  logic [Y_W-1:0]    pix_row;
  logic              pix_in_map;
  logic [ADDR_W-1:0] pix_addr;

  assign pix_col    = x >> TILE_SHIFT;
  assign pix_row    = y >> TILE_SHIFT;
  assign pix_in_map = (32'(pix_col) < 32'(TILE_COLS)) && (32'(pix_row) < 32'(TILE_ROWS));
  // Off-map pixels read address 0; the result is masked by the registered in-map flag.
  assign pix_addr   = pix_in_map ? ADDR_W'(32'(pix_row) * 32'(TILE_COLS) + 32'(pix_col)) : '0;

  // ---------------- map write port: clear sweep owns it while busy ----------------
  logic              wr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic              mem_wd;

  assign wr_ok   = wr_en && !map_busy &&
                   (32'(wr_col) < 32'(TILE_COLS)) && (32'(wr_row) < 32'(TILE_ROWS));
  assign wr_addr = ADDR_W'(32'(wr_row) * 32'(TILE_COLS) + 32'(wr_col));
  assign mem_we  = map_busy | wr_ok;
  assign mem_wa  = map_busy ? clr_addr : wr_addr;
  assign mem_wd  = !map_busy & wr_data;

  // ---------------- clear FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      map_busy <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_map) begin
            state    <= CLEAR;
            map_busy <= 1'b1;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= IDLE;
            map_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          map_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- S1: coordinates, tile address, sprite parameters ----------------
  logic                       s1_vld, s1_in_map, s1_origin;
  logic [X_W-1:0]             s1_x;
  logic [Y_W-1:0]             s1_y;
  logic [ADDR_W-1:0]          s1_addr;
  logic [NUM_SPRITES-1:0]     s1_en;
  logic [NUM_SPRITES*X_W-1:0] s1_left, s1_right;
  logic [NUM_SPRITES*Y_W-1:0] s1_top, s1_bot;
  logic [NUM_SPRITES*24-1:0]  s1_rgb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld    <= 1'b0;
      s1_in_map <= 1'b0;
      s1_origin <= 1'b0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_addr   <= '0;
      s1_en     <= '0;
      s1_left   <= '0;
      s1_right  <= '0;
      s1_top    <= '0;
      s1_bot    <= '0;
      s1_rgb    <= '0;
    end else begin
      s1_vld    <= pix_valid;
      s1_in_map <= pix_in_map;
      s1_origin <= (x == '0) && (y == '0);
      s1_x      <= x;
      s1_y      <= y;
      s1_addr   <= pix_addr;
      s1_en     <= spr_en;
      s1_left   <= spr_left;
      s1_right  <= spr_right;
      s1_top    <= spr_top;
      s1_bot    <= spr_bot;
      s1_rgb    <= spr_rgb;
    end
  end

  // Inverted bounds (left > right or top > bot) fail one of the compares, so they never hit.
  logic [NUM_SPRITES-1:0] s1_hit;
  always_comb begin
    s1_hit = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      s1_hit[i] = s1_en[i] &&
                  (s1_x >= s1_left[i*X_W +: X_W]) && (s1_x <= s1_right[i*X_W +: X_W]) &&
                  (s1_y >= s1_top[i*Y_W +: Y_W])  && (s1_y <= s1_bot[i*Y_W +: Y_W]);
    end
  end

  // ---------------- S2: tile map read and registered sprite hits ----------------
  logic mem [0:DEPTH-1];
  logic rd_bit;

  // Read-before-write: a read of the tile being written this cycle returns the old value.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    rd_bit <= mem[s1_addr];
  end

  logic                      s2_vld, s2_in_map, s2_origin;
  logic [NUM_SPRITES-1:0]    s2_hit;
  logic [NUM_SPRITES*24-1:0] s2_rgb;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_vld    <= 1'b0;
      s2_in_map <= 1'b0;
      s2_origin <= 1'b0;
      s2_hit    <= '0;
      s2_rgb    <= '0;
    end else begin
      s2_vld    <= s1_vld;
      s2_in_map <= s1_in_map;
      s2_origin <= s1_origin;
      s2_hit    <= s1_hit;
      s2_rgb    <= s1_rgb;
    end
  end

  // ---------------- S3: colour priority and collision accumulate ----------------
  logic                   s2_wall;
  logic [23:0]            pix_rgb;
  logic [NUM_SPRITES-1:0] contrib;

  always_comb begin
    s2_wall = rd_bit & s2_in_map;
    pix_rgb = s2_wall ? WALL_RGB : BG_RGB;
    // Walk from the highest index down so the lowest-index hitting sprite wins.
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (s2_hit[i]) pix_rgb = s2_rgb[i*24 +: 24];
    end
    contrib = s2_vld ? (s2_hit & {NUM_SPRITES{s2_wall}}) : '0;
  end

  logic [NUM_SPRITES-1:0] acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r          <= 8'h00;
      g          <= 8'h00;
      b          <= 8'h00;
      rgb_valid  <= 1'b0;
      frame_done <= 1'b0;
      collide    <= '0;
      acc        <= '0;
    end else begin
      rgb_valid  <= s2_vld;
      {r, g, b}  <= s2_vld ? pix_rgb : 24'h000000;
      frame_done <= s2_vld & s2_origin;
      // Origin pixel closes the previous frame and seeds the next one with its own contribution.
      if (s2_vld && s2_origin) begin
        collide <= acc;
        acc     <= contrib;
      end else begin
        acc     <= acc | contrib;
      end
    end
  end

endmodule

// File: tb/tb_maze_pixel_renderer.sv
module tb_maze_pixel_renderer;

  localparam int NS = 2;
  localparam int XW = 10;
  localparam int YW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [XW-1:0] x = '0;
  logic [YW-1:0] y = '0;
  logic          pix_valid = 1'b0;
  logic          wr_en = 1'b0;
  logic [6:0]    wr_col = '0;
  logic [5:0]    wr_row = '0;
  logic          wr_data = 1'b0;
  logic          clr_map = 1'b0;
  logic          map_busy;
  logic [NS-1:0]    spr_en = '0;
  logic [NS*XW-1:0] spr_left = '0, spr_right = '0;
  logic [NS*YW-1:0] spr_top = '0, spr_bot = '0;
  logic [NS*24-1:0] spr_rgb = '0;
  logic [7:0]    r, g, b;
  logic          rgb_valid;
  logic [NS-1:0] collide;
  logic          frame_done;

  maze_pixel_renderer #(.NUM_SPRITES(NS)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .pix_valid(pix_valid),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .clr_map(clr_map), .map_busy(map_busy),
    .spr_en(spr_en), .spr_left(spr_left), .spr_right(spr_right),
    .spr_top(spr_top), .spr_bot(spr_bot), .spr_rgb(spr_rgb),
    .r(r), .g(g), .b(b), .rgb_valid(rgb_valid), .collide(collide), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]   rgb;
    logic          vld;
    logic [NS-1:0] col;
    logic          fd;
  } exp_t;

  exp_t          q[$];
  bit            m_map [0:4799];
  logic [NS-1:0] m_acc = '0;
  logic [NS-1:0] m_collide = '0;
  bit            m_sweeping = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: evaluates the pixel currently on the inputs and advances the frame collision model.
  task automatic model_step(output exp_t e);
    int px, py, col, row, l, rr, t, bt;
    bit wall, found;
    logic [23:0]   c;
    logic [NS-1:0] hits, contrib;
    px = int'(x); py = int'(y);
    col = px / 8; row = py / 8;
    wall = (col < 80) && (row < 60) && m_map[row*80 + col];
    c = wall ? 24'h0000FF : 24'h000000;
    hits = '0; found = 0;
    for (int i = 0; i < NS; i++) begin
      l  = int'(spr_left[i*XW +: XW]);  rr = int'(spr_right[i*XW +: XW]);
      t  = int'(spr_top[i*YW +: YW]);   bt = int'(spr_bot[i*YW +: YW]);
      if (spr_en[i] && px >= l && px <= rr && py >= t && py <= bt) begin
        hits[i] = 1'b1;
        if (!found) begin
          c = spr_rgb[i*24 +: 24];
          found = 1;
        end
      end
    end
    e.vld = pix_valid;
    e.rgb = pix_valid ? c : 24'h000000;
    contrib = (pix_valid && wall) ? hits : '0;
    if (pix_valid && px == 0 && py == 0) begin
      m_collide = m_acc;
      m_acc = contrib;
      e.fd = 1'b1;
    end else begin
      m_acc = m_acc | contrib;
      e.fd = 1'b0;
    end
    e.col = m_collide;
  endtask

  // One clock: predict from current inputs, apply the edge, compare the pixel issued 3 cycles ago.
  task automatic tick();
    exp_t e;
    model_step(e);
    if (wr_en && !m_sweeping && wr_col < 80 && wr_row < 60)
      m_map[int'(wr_row)*80 + int'(wr_col)] = wr_data;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() >= 3) begin
      e = q.pop_front();
      chk("rgb",        {8'h00, r, g, b},   {8'h00, e.rgb});
      chk("rgb_valid",  32'(rgb_valid),     32'(e.vld));
      chk("collide",    32'(collide),       32'(e.col));
      chk("frame_done", 32'(frame_done),    32'(e.fd));
    end
  endtask

  task automatic pix(input int px, input int py, input bit v);
    x = XW'(px); y = YW'(py); pix_valid = v;
    tick();
  endtask

  task automatic wr(input int c, input int rr, input bit d);
    pix_valid = 0; wr_en = 1; wr_col = 7'(c); wr_row = 6'(rr); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic set_spr(input int i, input bit en, input int l, input int rr,
                         input int t, input int bt, input logic [23:0] c);
    spr_en[i] = en;
    spr_left[i*XW +: XW]  = XW'(l);
    spr_right[i*XW +: XW] = XW'(rr);
    spr_top[i*YW +: YW]   = YW'(t);
    spr_bot[i*YW +: YW]   = YW'(bt);
    spr_rgb[i*24 +: 24]   = c;
  endtask

  // Called at posedge+1; asserts reset between edges and checks outputs drop at once.
  task automatic do_reset();
    #3 reset = 0;
    #1;
    chk("rst_rgb",        {8'h00, r, g, b}, 32'h0);
    chk("rst_rgb_valid",  32'(rgb_valid),   32'h0);
    chk("rst_collide",    32'(collide),     32'h0);
    chk("rst_frame_done", 32'(frame_done),  32'h0);
    chk("rst_map_busy",   32'(map_busy),    32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    q.delete();
    m_acc = '0; m_collide = '0;
  endtask

  task automatic do_clear();
    int n;
    pix_valid = 0; clr_map = 1;
    tick();
    clr_map = 0;
    m_sweeping = 1; n = 0;
    while (map_busy && n < 6000) begin
      wr_en = 1; wr_data = 1;
      wr_col = 7'($urandom_range(0, 79)); wr_row = 6'($urandom_range(0, 59));
      n++;
      tick();
    end
    wr_en = 0; m_sweeping = 0;
    chk("busy_cycles", 32'(n), 32'd4800);
    for (int i = 0; i < 4800; i++) m_map[i] = 0;
  endtask

  initial begin
    int l, w, t, h;
    @(posedge clk); #1;
    do_reset();
    do_clear();

    // Single wall tile, edge of tile, off-map column, invalid pixel.
    wr(3, 2, 1);
    pix(0, 0, 0); pix(0, 0, 0);
    pix(24, 16, 1); pix(23, 16, 1); pix(645, 16, 1); pix(24, 16, 0);

    // Sprite priority.
    set_spr(0, 1, 100, 107, 50, 57, 24'h00FF00);
    set_spr(1, 1, 100, 107, 50, 57, 24'hFF0000);
    pix(104, 52, 1);
    spr_en[0] = 0;
    pix(104, 52, 1);

    // Collision over tile (3,2), then moved off the walls.
    set_spr(0, 1, 24, 31, 16, 23, 24'h00FF00);
    spr_en[1] = 0;
    pix(0, 0, 1); pix(25, 17, 1); pix(300, 300, 1); pix(30, 22, 0);
    pix(0, 0, 1); pix(200, 100, 1);
    set_spr(0, 1, 100, 107, 50, 57, 24'h00FF00);
    pix(104, 52, 1); pix(0, 0, 1); pix(5, 5, 1);
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);

    // Random wall map.
    for (int k = 0; k < 1500; k++)
      wr($urandom_range(0, 79), $urandom_range(0, 59), $urandom_range(0, 2) != 0);
    pix(0, 0, 0); pix(0, 0, 0);

    // Random sprites and pixels with periodic frame starts and a mid-frame reset.
    for (int k = 0; k < 15000; k++) begin
      if (k % 64 == 0) begin
        for (int i = 0; i < NS; i++) begin
          l = $urandom_range(0, 700); w = $urandom_range(0, 120);
          t = $urandom_range(0, 480); h = $urandom_range(0, 80);
          if (l + w > 1023) w = 1023 - l;
          if (t + h > 511)  h = 511 - t;
          if ($urandom_range(0, 7) == 0 && w > 0)
            set_spr(i, $urandom_range(0, 3) != 0, l + w, l, t, t + h, 24'($urandom));
          else
            set_spr(i, $urandom_range(0, 3) != 0, l, l + w, t, t + h, 24'($urandom));
        end
      end
      if (k == 7000) do_reset();
      if ($urandom_range(0, 39) == 0) pix(0, 0, 1);
      else pix($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 4) != 0);
    end

    // Reset in the middle of a sweep, then a full sweep with writes attempted during it.
    pix_valid = 0; clr_map = 1;
    tick();
    clr_map = 0; m_sweeping = 1;
    repeat (100) tick();
    m_sweeping = 0;
    do_reset();
    do_clear();
    pix(0, 0, 0); pix(0, 0, 0);

    // After the clear every pixel must read as background.
    spr_en = '0;
    for (int k = 0; k < 2000; k++)
      pix($urandom_range(0, 700), $urandom_range(0, 500), $urandom_range(0, 4) != 0);
    pix(0, 0, 0); pix(0, 0, 0); pix(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maze_pixel_renderer.md
# maze_pixel_renderer

Parametrised per-pixel renderer for the maze game: holds a writable 1-bit wall tile map, overlays NUM_SPRITES rectangular player sprites, and produces registered RGB for video_driver from its x/y scan coordinates. Accumulates per-sprite wall collisions over each frame and reports them once per frame. Sits between video_driver (x, y) and game logic (sprite bounds, map writes), replacing the fixed-level colour mux in the top level.

## Interface
- TILE_SHIFT, 3: log2 of tile size in pixels (8x8 tiles)
- TILE_COLS, 80: map width in tiles
- TILE_ROWS, 60: map height in tiles
- NUM_SPRITES, 2: number of sprite channels (1..8)
- X_W, 10: x coordinate width
- Y_W, 9: y coordinate width
- WALL_RGB, 24'h0000FF: wall colour {r,g,b}
- BG_RGB, 24'h000000: background colour
---
- clk  in  1  single clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset
- x  in  X_W  pixel column from video_driver
- y  in  Y_W  pixel row from video_driver
- pix_valid  in  1  x/y is an active pixel
- wr_en  in  1  tile map write strobe
- wr_col  in  $clog2(TILE_COLS)  write tile column
- wr_row  in  $clog2(TILE_ROWS)  write tile row
- wr_data  in  1  1 = wall
- clr_map  in  1  start full-map clear (pulse)
- map_busy  out  1  clear sweep in progress
- spr_en  in  NUM_SPRITES  per-sprite enable
- spr_left, spr_right  in  NUM_SPRITES*X_W  inclusive x bounds, packed, sprite i at [i*X_W +: X_W]
- spr_top, spr_bot  in  NUM_SPRITES*Y_W  inclusive y bounds, top <= bot
- spr_rgb  in  NUM_SPRITES*24  sprite colours {r,g,b}
- r, g, b  out  8 each  pixel colour
- rgb_valid  out  1  r/g/b correspond to a valid pixel
- collide  out  NUM_SPRITES  sprite i overlapped a wall tile during last complete frame
- frame_done  out  1  one-cycle pulse when collide updates

## Operation
- Tile index: col = x >> TILE_SHIFT, row = y >> TILE_SHIFT. col >= TILE_COLS or row >= TILE_ROWS reads as non-wall.
- Tile map: TILE_ROWS*TILE_COLS bits, synchronous read, one write port. Same-cycle write and read of one tile returns old value. Contents not initialised by reset.
- Sprite hit i: spr_en[i] & left_i <= x <= right_i & top_i <= y <= bot_i. A sprite with left > right or top > bot never hits.
- Colour priority: lowest-index hitting sprite > wall > BG_RGB. pix_valid low: r/g/b = 0, rgb_valid = 0.
- Collision: valid pixel with sprite i hit and wall set sets acc[i]. When a valid pixel with x = 0, y = 0 reaches output stage: collide <= acc (including no contribution from that pixel), acc <= that pixel's contribution, frame_done = 1 for that cycle.
- Clear FSM: IDLE -> CLEAR on clr_map. CLEAR writes 0 to one tile per cycle, row-major from (0,0); after last tile -> IDLE. map_busy = 1 in CLEAR. wr_en ignored while map_busy. clr_map ignored during CLEAR. Pixel reads during CLEAR return whatever the RAM holds (no stall).

## Timing
- 3-cycle latency x/y/pix_valid -> r/g/b/rgb_valid: S1 register coords and compute tile address; S2 RAM read and registered sprite compares; S3 priority mux and collision accumulate.
- Fully pipelined, one pixel per cycle, no back-pressure.
- Sprite bounds, spr_en and spr_rgb sampled at S1 with the pixel.
- Map write visible to a read issued the cycle after wr_en.
- Clear sweep: exactly TILE_ROWS*TILE_COLS cycles of map_busy, starting the cycle after clr_map.
- Reset (asynchronous assert, synchronous-safe deassert): r = g = b = 0, rgb_valid = 0, collide = 0, acc = 0, frame_done = 0, map_busy = 0, FSM IDLE, all pipeline valids 0. Reset during CLEAR aborts the sweep; partially cleared map is left as is.

## Test plan
- Write wall at tile (3,2); drive x = 24, y = 16 valid -> 3 cycles later rgb = 0000FF, rgb_valid = 1; x = 23 -> rgb = 000000.
- Sprite 0 bounds (100..107, 50..57) rgb 00FF00, sprite 1 same bounds rgb FF0000 -> pixel (104,52) outputs 00FF00; disable sprite 0 -> FF0000.
- Sprite 0 at (24..31, 16..23) over wall tile (3,2), scan full 640x480 frame twice -> frame_done pulses at second (0,0), collide = 01; move sprite off walls, next frame -> collide = 00.
- Write walls, pulse clr_map -> map_busy high 4800 cycles; wr_en during sweep ignored; afterwards every pixel reads BG.
- x = 645 (col 80) with pix_valid -> non-wall BG; pix_valid low -> rgb 0, rgb_valid 0, no collision.
- Assert reset mid-frame and mid-clear -> all outputs 0 immediately, map_busy 0, collide 0.
